// File: rtl/y_adder.sv
// 32-bit ripple-carry adder with a registered result copy.
// Define YADDER_OVF_EN to add the signed-overflow outputs ovf/ovf_q.
module y_adder_slice (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_p;

  assign w_p = i_a ^ i_b;
  assign o_s = w_p ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

module y_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  input  logic        en,
  output logic [31:0] z,
  output logic        cout,
  output logic [31:0] z_q,
  output logic        cout_q
`ifdef YADDER_OVF_EN
  ,
  output logic        ovf,
  output logic        ovf_q
`endif
);
  logic [32:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_slice
    y_adder_slice u_slice (
      .i_a (a[i]),
      .i_b (b[i]),
      .i_c (w_c[i]),
      .o_s (z[i]),
      .o_c (w_c[i+1])
    );
  end

  assign cout = w_c[32];

`ifdef YADDER_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf = w_c[31] ^ w_c[32];
`endif

  // Result register: async reset, enable-gated capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q    <= '0;
      cout_q <= 1'b0;
`ifdef YADDER_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (en) begin
      z_q    <= z;
      cout_q <= cout;
`ifdef YADDER_OVF_EN
      ovf_q  <= ovf;
`endif
    end
  end
endmodule

// File: tb/tb_y_adder.sv
// Directed self-checking bench for y_adder (combinational sum, carry, register, reset).
module tb_y_adder;
  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        en;
  logic [31:0] z;
  logic        cout;
  logic [31:0] z_q;
  logic        cout_q;
`ifdef YADDER_OVF_EN
  logic        ovf;
  logic        ovf_q;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  y_adder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .en     (en),
    .z      (z),
    .cout   (cout),
    .z_q    (z_q),
    .cout_q (cout_q)
`ifdef YADDER_OVF_EN
    ,
    .ovf    (ovf),
    .ovf_q  (ovf_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (z_q !== 32'h0) begin n_fail++; $display("FAIL reset_zq got %h exp %h", z_q, 32'h0); end
    n_checks++;
    if (cout_q !== 1'b0) begin n_fail++; $display("FAIL reset_coutq got %b exp 0", cout_q); end
`ifdef YADDER_OVF_EN
    n_checks++;
    if (ovf_q !== 1'b0) begin n_fail++; $display("FAIL reset_ovfq got %b exp 0", ovf_q); end
`endif
  endtask

  task automatic test_directed();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic        vc [8];
    logic [31:0] ez [8];
    logic        ec [8];
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0;         vc[0] = 1; ez[0] = 32'h0;         ec[0] = 1;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0;         vc[1] = 0; ez[1] = 32'hFFFF_FFFF; ec[1] = 0;
    va[2] = 32'd5;         vb[2] = 32'd7;         vc[2] = 0; ez[2] = 32'd12;        ec[2] = 0;
    va[3] = 32'd0;         vb[3] = 32'd0;         vc[3] = 1; ez[3] = 32'd1;         ec[3] = 0;
    va[4] = 32'h1234_5678; vb[4] = 32'h8765_4321; vc[4] = 0; ez[4] = 32'h9999_9999; ec[4] = 0;
    va[5] = 32'hDEAD_BEEF; vb[5] = 32'h1111_1111; vc[5] = 1; ez[5] = 32'hEFBE_D001; ec[5] = 0;
    va[6] = 32'h8000_0001; vb[6] = 32'h8000_0001; vc[6] = 1; ez[6] = 32'h0000_0003; ec[6] = 1;
    va[7] = 32'hAAAA_AAAA; vb[7] = 32'h5555_5555; vc[7] = 1; ez[7] = 32'h0;         ec[7] = 1;
    for (int i = 0; i < 8; i++) begin
      a = va[i]; b = vb[i]; cin = vc[i];
      #1;
      n_checks++;
      if (z !== ez[i] || cout !== ec[i]) begin
        n_fail++;
        $display("FAIL directed_%0d got z=%h cout=%b exp z=%h cout=%b", i, z, cout, ez[i], ec[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [32:0] exp_sum;
    for (int i = 0; i < 12; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      exp_sum = {1'b0, a} + {1'b0, b} + {32'h0, cin};
      #1;
      n_checks++;
      if ({cout, z} !== exp_sum) begin
        n_fail++;
        $display("FAIL random_%0d a=%h b=%h cin=%b got %h exp %h", i, a, b, cin, {cout, z}, exp_sum);
      end
    end
  endtask

`ifdef YADDER_OVF_EN
  task automatic test_overflow();
    a = 32'h7FFF_FFFF; b = 32'd1; cin = 1'b0;
    #1;
    n_checks++;
    if (z !== 32'h8000_0000 || cout !== 1'b0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pos got z=%h cout=%b ovf=%b exp 80000000 0 1", z, cout, ovf);
    end
    a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b0;
    #1;
    n_checks++;
    if (z !== 32'h0 || cout !== 1'b1 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_neg got z=%h cout=%b ovf=%b exp 00000000 1 1", z, cout, ovf);
    end
    a = 32'd5; b = 32'd7; cin = 1'b0;
    #1;
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_none got %b exp 0", ovf); end
  endtask
`endif

  task automatic test_register();
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1; a = 32'd3; b = 32'd4; cin = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (z_q !== 32'd8 || cout_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_capture got z_q=%h cout_q=%b exp 00000008 0", z_q, cout_q);
    end
    @(negedge clk);
    en = 1'b0; a = 32'hFFFF_FFFF; b = 32'd1; cin = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (z_q !== 32'd8 || cout_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_hold got z_q=%h cout_q=%b exp 00000008 0", z_q, cout_q);
    end
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (z_q !== 32'h0 || cout_q !== 1'b1) begin
      n_fail++;
      $display("FAIL reg_carry got z_q=%h cout_q=%b exp 00000000 1", z_q, cout_q);
    end
`ifdef YADDER_OVF_EN
    n_checks++;
    if (ovf_q !== 1'b0) begin n_fail++; $display("FAIL reg_ovfq got %b exp 0", ovf_q); end
`endif
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a = 32'd3; b = 32'd4; cin = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (z_q !== 32'd8) begin n_fail++; $display("FAIL rst_pre got %h exp 00000008", z_q); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (z_q !== 32'h0 || cout_q !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async got z_q=%h cout_q=%b exp 00000000 0", z_q, cout_q);
    end
    a = 32'd10; b = 32'd20; cin = 1'b0;
    #1;
    n_checks++;
    if (z !== 32'd30) begin n_fail++; $display("FAIL rst_comb got %h exp 0000001e", z); end
    @(posedge clk); #1;
    n_checks++;
    if (z_q !== 32'h0) begin n_fail++; $display("FAIL rst_wins got %h exp 00000000", z_q); end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (z_q !== 32'h0) begin n_fail++; $display("FAIL rst_release_hold got %h exp 00000000", z_q); end
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (z_q !== 32'd30) begin n_fail++; $display("FAIL rst_release_cap got %h exp 0000001e", z_q); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
`ifdef YADDER_OVF_EN
    test_overflow();
`endif
    test_register();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
